// File: rtl/ddr5_phy_wrdata_dqs_gen.sv
// ddr5_phy_wrdata_dqs_gen: fixed-latency write data path with DQS preamble/postamble sequencing
module ddr5_phy_wrdata_dqs_gen #(
    parameter int pDRAM_SIZE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    dfi_wrdata_en_i,
    input  logic [2*pDRAM_SIZE-1:0] dfi_wrdata_i,
    input  logic [pDRAM_SIZE/4-1:0] dfi_wrdata_mask_i,
    input  logic [1:0]              pre_len_i,
    input  logic                    post_len_i,
    output logic [2*pDRAM_SIZE-1:0] dq_o,
    output logic [pDRAM_SIZE/4-1:0] dm_o,
    output logic                    dq_oe_o,
    output logic [1:0]              dqs_o,
    output logic                    dqs_oe_o,
    output logic                    burst_err_o
);
    localparam int DW = 2*pDRAM_SIZE;
    localparam int MW = pDRAM_SIZE/4;
    localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, POST = 2'd3;
    logic [3:0] en_q, en_d;
    logic [3:0][DW-1:0] dat_q, dat_d;
    logic [3:0][MW-1:0] msk_q, msk_d;
    logic [1:0] state_q, state_d, pcnt_q, pcnt_d, pre_q, pre_d, dqs_q, dqs_d;
    logic post_q, post_d, dq_oe_q, dq_oe_d, dqs_oe_q, dqs_oe_d, err_q, err_d;
    logic [2:0] cnt_q, cnt_d, gap_len;
    logic [DW-1:0] dq_q, dq_d;
    logic [MW-1:0] dm_q, dm_d;
    logic [1:0] p_in;
    logic start, seam, burst_end, go_pre;
    // stage k of en_q holds the enable sampled k+1 edges ago; a preamble of P starts when stage 3-P sees the burst
    always_comb begin
        en_d = {en_q[2:0], dfi_wrdata_en_i};
        dat_d = {dat_q[2:0], dfi_wrdata_i};
        msk_d = {msk_q[2:0], dfi_wrdata_mask_i};
        p_in = (pre_len_i == 2'b00) ? 2'd1 : (pre_len_i == 2'b01) ? 2'd2 : 2'd3;
        start = (p_in == 2'd1) ? en_q[2] : (p_in == 2'd2) ? en_q[1] : en_q[0];
        gap_len = {1'b0, pre_q} + {2'b00, post_q};
        seam = (gap_len >= 3'd2 && en_q[2]) || (gap_len >= 3'd3 && en_q[1]) || (gap_len >= 3'd4 && en_q[0]);
        burst_end = state_q == DATA && !en_q[3] && dq_oe_q;
        go_pre = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: go_pre = start;
            PRE: state_d = (pcnt_q == 2'd0) ? DATA : PRE;
            DATA: if (!en_q[3] && !seam) begin
                state_d = post_q ? POST : IDLE;
                go_pre = !post_q && start;
            end
            default: begin
                state_d = IDLE;
                go_pre = start;
            end
        endcase
        pcnt_d = (state_q == PRE && pcnt_q != 2'd0) ? pcnt_q - 2'd1 : pcnt_q;
        pre_d = go_pre ? p_in : pre_q;
        post_d = go_pre ? post_len_i : post_q;
        pcnt_d = go_pre ? p_in - 2'd1 : pcnt_d;
        state_d = go_pre ? PRE : state_d;
        cnt_d = burst_end ? 3'd0 : (state_d == DATA && en_q[3]) ? cnt_q + 3'd1 : cnt_q;
        err_d = burst_end && cnt_q != 3'd0;
        dqs_oe_d = state_d != IDLE;
        dqs_d = (state_d == DATA || (state_d == PRE && pcnt_d == 2'd0)) ? 2'b01 : 2'b00;
        dq_oe_d = state_d == DATA && en_q[3];
        dq_d = (state_d == DATA) ? dat_q[3] : '0;
        dm_d = (state_d == DATA) ? msk_q[3] : '0;
        if (!enable_i) begin
            en_d = '0;
            dat_d = '0;
            msk_d = '0;
            state_d = IDLE;
            pcnt_d = '0;
            pre_d = '0;
            post_d = 1'b0;
            cnt_d = '0;
            err_d = 1'b0;
            dqs_oe_d = 1'b0;
            dqs_d = '0;
            dq_oe_d = 1'b0;
            dq_d = '0;
            dm_d = '0;
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            en_q <= '0;
            dat_q <= '0;
            msk_q <= '0;
            state_q <= IDLE;
            pcnt_q <= '0;
            pre_q <= '0;
            post_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
            dqs_oe_q <= 1'b0;
            dqs_q <= '0;
            dq_oe_q <= 1'b0;
            dq_q <= '0;
            dm_q <= '0;
        end else begin
            en_q <= en_d;
            dat_q <= dat_d;
            msk_q <= msk_d;
            state_q <= state_d;
            pcnt_q <= pcnt_d;
            pre_q <= pre_d;
            post_q <= post_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            dqs_oe_q <= dqs_oe_d;
            dqs_q <= dqs_d;
            dq_oe_q <= dq_oe_d;
            dq_q <= dq_d;
            dm_q <= dm_d;
        end
    end
    assign dq_o = dq_q;
    assign dm_o = dm_q;
    assign dq_oe_o = dq_oe_q;
    assign dqs_o = dqs_q;
    assign dqs_oe_o = dqs_oe_q;
    assign burst_err_o = err_q;
endmodule

// File: tb/tb_ddr5_phy_wrdata_dqs_gen.sv
// tb_ddr5_phy_wrdata_dqs_gen: scoreboard bench, expected strobe/data events queued at stimulus time
module tb_ddr5_phy_wrdata_dqs_gen;
    localparam int DW = 8;
    localparam int MW = 1;
    logic clk_i = 1'b0, rst_i = 1'b1, enable_i = 1'b0, dfi_wrdata_en_i = 1'b0, post_len_i = 1'b0;
    logic [DW-1:0] dfi_wrdata_i = '0;
    logic [MW-1:0] dfi_wrdata_mask_i = '0;
    logic [1:0] pre_len_i = 2'b00;
    logic [DW-1:0] dq_o;
    logic [MW-1:0] dm_o;
    logic dq_oe_o, dqs_oe_o, burst_err_o;
    logic [1:0] dqs_o;
    int checks = 0, errors = 0, edge_no = 0, n = 0;
    logic [29:0] exp_q[$];
    ddr5_phy_wrdata_dqs_gen #(.pDRAM_SIZE(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .dfi_wrdata_en_i(dfi_wrdata_en_i),
        .dfi_wrdata_i(dfi_wrdata_i), .dfi_wrdata_mask_i(dfi_wrdata_mask_i), .pre_len_i(pre_len_i),
        .post_len_i(post_len_i), .dq_o(dq_o), .dm_o(dm_o), .dq_oe_o(dq_oe_o), .dqs_o(dqs_o),
        .dqs_oe_o(dqs_oe_o), .burst_err_o(burst_err_o)
    );
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) edge_no <= edge_no + 1;
    function automatic logic [29:0] ev(int t, logic oe, logic [1:0] dqs, logic dqoe, logic [DW-1:0] dq, logic [MW-1:0] dm, logic err);
        return {t[15:0], oe, dqs, dqoe, dq, dm, err};
    endfunction
    task automatic chk(string name, logic [29:0] got, logic [29:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_no, got, exp);
        end
    endtask
    task automatic push_burst(int nn, int p, logic post, int len, logic [7:0] base, int upto);
        for (int j = 0; j < p; j++) exp_q.push_back(ev(nn + 4 - p + j, 1'b1, (j == p - 1) ? 2'b01 : 2'b00, 1'b0, '0, '0, 1'b0));
        for (int i = 0; i < upto; i++) exp_q.push_back(ev(nn + 4 + i, 1'b1, 2'b01, 1'b1, base + 8'(i * 17), MW'(i % 2), 1'b0));
        if (upto == len && (post || len % 8 != 0)) exp_q.push_back(ev(nn + 4 + len, post, 2'b00, 1'b0, '0, '0, len % 8 != 0));
    endtask
    task automatic drive(int len, logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            dfi_wrdata_en_i = 1'b1;
            dfi_wrdata_i = base + 8'(i * 17);
            dfi_wrdata_mask_i = MW'(i % 2);
            if (i == 4) begin
                pre_len_i = ~pre_len_i;
                post_len_i = ~post_len_i;
            end
            @(negedge clk_i);
        end
        dfi_wrdata_en_i = 1'b0;
        dfi_wrdata_i = '0;
        dfi_wrdata_mask_i = '0;
    endtask
    task automatic burst(logic [1:0] pl, logic po, int len, logic [7:0] base);
        pre_len_i = pl;
        post_len_i = po;
        @(negedge clk_i);
        push_burst(edge_no + 1, (pl == 2'b00) ? 1 : (pl == 2'b01) ? 2 : 3, po, len, base, len);
        drive(len, base);
        repeat (8) @(negedge clk_i);
    endtask
    always @(negedge clk_i) begin
        if (dqs_oe_o || dq_oe_o || burst_err_o) begin
            if (exp_q.size() == 0) chk("unexpected_event", ev(edge_no, dqs_oe_o, dqs_o, dq_oe_o, dq_o, dm_o, burst_err_o), '0);
            else chk("event", ev(edge_no, dqs_oe_o, dqs_o, dq_oe_o, dq_o, dm_o, burst_err_o), exp_q.pop_front());
        end else begin
            chk("idle", 30'({dqs_o, dq_oe_o, dq_o, dm_o}), '0);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        #1 rst_i = 1'b0;
        #1 chk("reset", 30'({dqs_oe_o, dqs_o, dq_oe_o, dq_o, dm_o, burst_err_o}), '0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        enable_i = 1'b1;
        repeat (4) @(negedge clk_i);
        burst(2'b01, 1'b1, 8, 8'hA5);
        burst(2'b00, 1'b0, 8, 8'h3C);
        burst(2'b11, 1'b1, 8, 8'h5A);
        pre_len_i = 2'b10;
        post_len_i = 1'b1;
        @(negedge clk_i);
        n = edge_no + 1;
        push_burst(n, 3, 1'b1, 9, 8'h11, 8);
        exp_q.push_back(ev(n + 12, 1'b1, 2'b01, 1'b0, '0, '0, 1'b0));
        for (int i = 0; i < 8; i++) exp_q.push_back(ev(n + 13 + i, 1'b1, 2'b01, 1'b1, 8'h77 + 8'(i * 17), MW'(i % 2), 1'b0));
        exp_q.push_back(ev(n + 21, 1'b1, 2'b00, 1'b0, '0, '0, 1'b0));
        drive(8, 8'h11);
        @(negedge clk_i);
        drive(8, 8'h77);
        repeat (8) @(negedge clk_i);
        burst(2'b01, 1'b1, 5, 8'hC3);
        burst(2'b00, 1'b0, 5, 8'h96);
        pre_len_i = 2'b01;
        post_len_i = 1'b1;
        @(negedge clk_i);
        n = edge_no + 1;
        push_burst(n, 2, 1'b1, 8, 8'hE1, 3);
        fork
            drive(8, 8'hE1);
            begin
                wait (edge_no == n + 7);
                #1 rst_i = 1'b0;
                #1 chk("async_reset", 30'({dqs_oe_o, dqs_o, dq_oe_o, dq_o, dm_o, burst_err_o}), '0);
            end
        join
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (6) @(negedge clk_i);
        pre_len_i = 2'b10;
        post_len_i = 1'b1;
        @(negedge clk_i);
        n = edge_no + 1;
        exp_q.push_back(ev(n + 1, 1'b1, 2'b00, 1'b0, '0, '0, 1'b0));
        fork
            drive(8, 8'h4B);
            begin
                wait (edge_no == n + 1);
                @(negedge clk_i);
                enable_i = 1'b0;
            end
        join
        repeat (2) @(negedge clk_i);
        enable_i = 1'b1;
        repeat (4) @(negedge clk_i);
        burst(2'b10, 1'b1, 8, 8'h2D);
        repeat (4) @(negedge clk_i);
        chk("drain", 30'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr5_phy_wrdata_dqs_gen.md
DDR5_PHY_WRDATA_DQS_GEN -- requirements
Module: ddr5_phy_wrdata_dqs_gen

Interface
REQ-001 Parameter pDRAM_SIZE, default 4, DRAM device width (4, 8 or 16).
REQ-002 Port clk_i  in  1  single PHY clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port rst_i  in  1  reset; asynchronous, active-low.
REQ-004 Port enable_i  in  1  block enable, driven by the same enable as the upstream frequency-ratio stage.
REQ-005 Port dfi_wrdata_en_i  in  1  serialized write-data enable from the frequency-ratio stage.
REQ-006 Port dfi_wrdata_i  in  2*pDRAM_SIZE  two data beats per clock; [pDRAM_SIZE-1:0] is beat 0 and [2*pDRAM_SIZE-1:pDRAM_SIZE] is beat 1.
REQ-007 Port dfi_wrdata_mask_i  in  pDRAM_SIZE/4  write data mask for the cycle.
REQ-008 Port pre_len_i  in  2  write preamble length: 00=1, 01=2, 10=3, 11=3 cycles.
REQ-009 Port post_len_i  in  1  postamble length: 0=0 cycles, 1=1 cycle.
REQ-010 Port dq_o  out  2*pDRAM_SIZE  DQ beats to the IO serializer.
REQ-011 Port dm_o  out  pDRAM_SIZE/4  data mask to the IO.
REQ-012 Port dq_oe_o  out  1  DQ/DM output enable.
REQ-013 Port dqs_o  out  2  strobe half-cycle pattern; bit0 is the first half, bit1 the second half.
REQ-014 Port dqs_oe_o  out  1  DQS output enable.
REQ-015 Port burst_err_o  out  1  one-cycle pulse marking an illegal burst length.

Function
REQ-016 Fixed latency: dfi_wrdata_en_i/data/mask sampled at edge N SHALL appear on dq_o/dm_o/dq_oe_o after edge N+4, via a 4-stage register pipeline.
REQ-017 The FSM SHALL have the states IDLE, PRE, DATA and POST.
REQ-018 IDLE: dqs_oe_o=0, dqs_o=00, dq_oe_o=0, dq_o=0, dm_o=0.
REQ-019 IDLE->PRE: when a new burst is detected, pre_len_i is latched as P, and the PRE outputs SHALL be visible after edges N+4-P .. N+3, where N is the edge that samples the burst's first enable.
REQ-020 pre_len_i and post_len_i SHALL be sampled only on the IDLE->PRE transition; changes at any other time are ignored until the next burst.
REQ-021 PRE: dqs_oe_o=1; dqs_o=00 in the first P-1 preamble cycles and 01 in the final preamble cycle; dq_oe_o=0.
REQ-022 DATA: dqs_o=01 and dqs_oe_o=1 every cycle; dq_oe_o follows the delayed enable; dq_o and dm_o follow the delayed data and mask.
REQ-023 DATA->POST when the delayed enable falls and post_len=1; POST SHALL last 1 cycle with dqs_oe_o=1, dqs_o=00, dq_oe_o=0, then return to IDLE.
REQ-024 DATA->IDLE directly when the delayed enable falls and post_len=0.
REQ-025 Seamless bursts: if the enable-low gap between bursts is shorter than P+post_len cycles, the FSM SHALL stay in DATA with dqs_o=01 and dqs_oe_o=1 through the gap, dq_oe_o=0 in gap cycles, and no new preamble.
REQ-026 A 3-bit beat-cycle counter SHALL count DATA cycles with the delayed enable high, wrapping at 8 (BL16 = 8 clocks), and clearing at each burst end.
REQ-027 burst_err_o SHALL pulse for 1 cycle, coincident with the first cycle after the last data cycle, when the counter is nonzero at burst end (length not a multiple of 8 cycles); state handling is unaffected.
REQ-028 enable_i=0 SHALL, at the next edge, clear the pipeline and counter, force IDLE, and drive IDLE outputs; the FSM and pipeline hold no state while enable_i=0.

Reset
REQ-029 rst_i low SHALL immediately clear all outputs, the pipeline, the latched P and post_len, and the counter, and force IDLE, including mid-burst.
REQ-030 After rst_i deasserts, the first burst SHALL be accepted only on an IDLE rising enable, with no residual outputs.

Verification
REQ-031 P=2, post=1, enable high 8 cycles from edge 10 -> dqs_oe_o high after edges 12..22; dqs_o 00,01, then 01 x8, then 00; dq_oe_o high after 14..21; burst_err_o stays 0.
REQ-032 pdram 4, data 8'hA5 at edge 10 -> dq_o=8'hA5 after edge 14; dm_o follows the mask with the same latency.
REQ-033 Two 8-cycle bursts with a 1-cycle gap, P=3, post=1 -> a single preamble; dqs_o=01 continuous across the gap; dq_oe_o low for 1 cycle.
REQ-034 A 5-cycle burst -> burst_err_o=1 for exactly 1 cycle, after the 5th data cycle.
REQ-035 rst_i asserted at the 4th DATA cycle -> all outputs 0 asynchronously; after release with no enable, outputs stay in IDLE values.
REQ-036 enable_i dropped mid-preamble -> IDLE outputs after the next edge; a later burst starts with a full preamble.
